shift_sequencer: RTL and testbench

Clocked controller for the 4-bit universal shift datapath. It accepts a parallel word, a 2-bit op code and a repeat count through a start/busy/done handshake. It then applies that operation once per clock until the count is exhausted. It is the driving side of the shifter's s1/s0 control interface: it sequences multi-step shifts and rotates that the combinational shifter performs only one step at a time.

---
 rtl/shift_sequencer_if.sv | 36 +++
 rtl/shift_sequencer.sv | 117 +++++++++++
 tb/tb_shift_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle for shift_sequencer.
// SHIFT_SERIAL_IN_EN adds the ser_in / ser_out pins.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
`ifdef SHIFT_SERIAL_IN_EN
  logic             ser_in;
  logic             ser_out;

  modport master (
    output start, op, count, data_in, ser_in,
    input  q, busy, done, ser_out
  );
  modport slave (
    input  start, op, count, data_in, ser_in,
    output q, busy, done, ser_out
  );
`else
  modport master (
    output start, op, count, data_in,
    input  q, busy, done
  );
  modport slave (
    input  start, op, count, data_in,
    output q, busy, done
  );
`endif
endinterface

// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate sequencer driving a 4-bit universal shifter.
// Optional macro SHIFT_SERIAL_IN_EN: serial fill input and shifted-out bit.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  shift_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             w_fill;
  logic [WIDTH-1:0] w_next;

`ifdef SHIFT_SERIAL_IN_EN
  logic r_ser_out;
  logic w_shout;

  assign w_fill      = bus.ser_in;
  assign bus.ser_out = r_ser_out;

  // Bit leaving the register on the current step
  always_comb begin
    w_shout = r_ser_out;
    unique case (r_op)
      2'b01:   w_shout = r_q[WIDTH-1];
      2'b10:   w_shout = r_q[0];
      2'b11:   w_shout = r_q[WIDTH-1];
      default: w_shout = r_ser_out;
    endcase
  end

  // Serial-out register, updated only on real steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ser_out <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_ser_out <= w_shout;
    end
  end
`else
  assign w_fill = 1'b0;
`endif

  assign bus.q    = r_q;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // One step of the latched operation
  always_comb begin
    w_next = r_q;
    unique case (r_op)
      2'b01:   w_next = {r_q[WIDTH-2:0], w_fill};
      2'b10:   w_next = {w_fill, r_q[WIDTH-1:1]};
      2'b11:   w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      default: w_next = r_q;
    endcase
  end

  // Sequencer FSM with registered q/busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_op    <= 2'b00;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_q    <= bus.data_in;
            r_op   <= bus.op;
            r_rem  <= bus.count;
            r_busy <= 1'b1;
            if (bus.count != '0) begin
              r_state <= S_SHIFT;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_q   <= w_next;
          r_rem <= r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
// Serial-pin checks are built only with SHIFT_SERIAL_IN_EN.
module tb_shift_sequencer;
  logic clk;
  logic rst;

  shift_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  int         dn_k;
  int         pulses;
  int         bcnt;
  logic [3:0] dq;
  logic [3:0] qtr [0:15];
  logic       sotr[0:15];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Launch one job; k counts cycles after the accept edge.
  task automatic run_job(input logic [1:0] o,
                         input logic [3:0] d,
                         input int         n,
                         input int         ign_k,
                         input logic [3:0] ign_d,
                         input bit         stop,
                         input logic [3:0] sin);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.count   = 3'(n);
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.op      = ~o;
    bus.count   = ~3'(n);
    bus.data_in = ~d;
    dn_k   = 0;
    pulses = 0;
    bcnt   = 0;
    dq     = 4'h0;
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      qtr[k] = bus.q;
`ifdef SHIFT_SERIAL_IN_EN
      sotr[k] = bus.ser_out;
      bus.ser_in = (k <= 4) ? sin[k-1] : 1'b0;
`else
      sotr[k] = 1'b0;
      if (sin == 4'hf) sotr[k] = 1'b1;
`endif
      if (bus.busy) bcnt++;
      if (bus.done) begin
        pulses++;
        if (dn_k == 0) begin
          dn_k = k;
          dq   = bus.q;
        end
      end
      bus.start = (k == ign_k);
      if (k == ign_k) bus.data_in = ign_d;
      if (stop && dn_k != 0) break;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    n_chk       = 0;
    n_err       = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.count   = 3'd0;
    bus.data_in = 4'h0;
`ifdef SHIFT_SERIAL_IN_EN
    bus.ser_in  = 1'b0;
`endif
    #2;
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
`ifdef SHIFT_SERIAL_IN_EN
    chk("rst_ser_out", 32'(bus.ser_out), 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // shift left 1011 by 1
    run_job(2'b01, 4'b1011, 1, 0, 4'h0, 1'b0, 4'h0);
    chk("sl1_q", 32'(dq), 32'b0110);
    chk("sl1_lat", 32'(dn_k), 32'd2);
    chk("sl1_pulses", 32'(pulses), 32'd1);
    chk("sl1_busy", 32'(bcnt), 32'd2);
    chk("sl1_hold", 32'(qtr[5]), 32'b0110);

    // shift right 1001 by 2
    run_job(2'b10, 4'b1001, 2, 0, 4'h0, 1'b0, 4'h0);
    chk("sr2_q", 32'(dq), 32'b0010);
    chk("sr2_mid", 32'(qtr[2]), 32'b0100);
    chk("sr2_lat", 32'(dn_k), 32'd3);

    // rotate left 1100 by 3
    run_job(2'b11, 4'b1100, 3, 0, 4'h0, 1'b0, 4'h0);
    chk("rl3_s1", 32'(qtr[2]), 32'b1001);
    chk("rl3_s2", 32'(qtr[3]), 32'b0011);
    chk("rl3_q", 32'(dq), 32'b0110);
    chk("rl3_lat", 32'(dn_k), 32'd4);

    // hold 1011 for 5 steps
    run_job(2'b00, 4'b1011, 5, 0, 4'h0, 1'b0, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("hold_q%0d", k), 32'(qtr[k]), 32'b1011);
    end
    chk("hold_lat", 32'(dn_k), 32'd6);
    chk("hold_busy", 32'(bcnt), 32'd6);

    // count zero
    run_job(2'b01, 4'b0101, 0, 0, 4'h0, 1'b0, 4'h0);
    chk("c0_q", 32'(dq), 32'b0101);
    chk("c0_lat", 32'(dn_k), 32'd1);
    chk("c0_pulses", 32'(pulses), 32'd1);

    // start during SHIFT is ignored; rotate 1000 by 4
    run_job(2'b11, 4'b1000, 4, 2, 4'b0101, 1'b0, 4'h0);
    chk("ign_q", 32'(dq), 32'b1000);
    chk("ign_lat", 32'(dn_k), 32'd5);
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_idle_q", 32'(qtr[8]), 32'b1000);

    // back-to-back: second start in IDLE right after DONE
    run_job(2'b01, 4'b0001, 2, 0, 4'h0, 1'b1, 4'h0);
    chk("b2b_a_q", 32'(dq), 32'b0100);
    chk("b2b_a_lat", 32'(dn_k), 32'd3);
    run_job(2'b10, 4'b1000, 1, 0, 4'h0, 1'b0, 4'h0);
    chk("b2b_b_q", 32'(dq), 32'b0100);
    chk("b2b_b_lat", 32'(dn_k), 32'd2);

    // async reset mid-SHIFT
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 2'b01;
    bus.count   = 3'd7;
    bus.data_in = 4'b1111;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q", 32'(bus.q), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_done", 32'(bus.done), 32'h0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("arst_nodone", 32'(pulses), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("arst_stale", 32'(pulses), 32'd0);
    run_job(2'b01, 4'b0011, 2, 0, 4'h0, 1'b0, 4'h0);
    chk("arst_job_q", 32'(dq), 32'b1100);
    chk("arst_job_lat", 32'(dn_k), 32'd3);

`ifdef SHIFT_SERIAL_IN_EN
    // serial fill 1,0,1,1 into 0000
    run_job(2'b01, 4'b0000, 4, 0, 4'h0, 1'b0, 4'b1101);
    chk("ser_q", 32'(dq), 32'b1011);
    chk("ser_s1", 32'(qtr[2]), 32'b0001);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("ser_out%0d", k), 32'(sotr[k]), 32'h0);
    end
    run_job(2'b10, 4'b1011, 1, 0, 4'h0, 1'b0, 4'b0000);
    chk("ser_sr_q", 32'(dq), 32'b0101);
    chk("ser_sr_out", 32'(sotr[2]), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
